// File: rtl/hazard_scheduler_pkg.sv
// Shared definitions for the 5-stage core's hazard scheduler: FSM encodings,
// forwarding selects and architectural register numbers.
package hazard_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_BRFLUSH = 2'd2,
    ST_MEMWAIT = 2'd3
  } state_t;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  localparam int REG_SP = 13;
  localparam int REG_LR = 14;
  localparam int REG_PC = 15;

  localparam logic [15:0] NOP_INSTR = 16'hBF00;

endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight destination tracking for EX/MEM/WB, plus the forwarding compare
// and load-use detection against the instruction currently in ID.
module hazard_scoreboard
  import hazard_scheduler_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shift_en,
  input  logic              load_en,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic              id_rs1_used,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              load_use,
  output logic              mem_pend
);

  logic              ex_v_reg, ex_wr_reg, ex_ld_reg, ex_st_reg;
  logic [REG_AW-1:0] ex_rd_reg;
  logic              mem_v_reg, mem_wr_reg, mem_ld_reg, mem_st_reg;
  logic [REG_AW-1:0] mem_rd_reg;
  logic              wb_v_reg, wb_wr_reg;
  logic [REG_AW-1:0] wb_rd_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_v_reg   <= 1'b0;
      ex_wr_reg  <= 1'b0;
      ex_ld_reg  <= 1'b0;
      ex_st_reg  <= 1'b0;
      ex_rd_reg  <= '0;
      mem_v_reg  <= 1'b0;
      mem_wr_reg <= 1'b0;
      mem_ld_reg <= 1'b0;
      mem_st_reg <= 1'b0;
      mem_rd_reg <= '0;
      wb_v_reg   <= 1'b0;
      wb_wr_reg  <= 1'b0;
      wb_rd_reg  <= '0;
    end else if (shift_en) begin
      // A held or flushed ID/EX register means nothing new enters EX.
      ex_v_reg   <= load_en & id_valid;
      ex_wr_reg  <= id_regwrite;
      ex_ld_reg  <= id_mem_read;
      ex_st_reg  <= id_mem_write;
      ex_rd_reg  <= id_rd;
      mem_v_reg  <= ex_v_reg;
      mem_wr_reg <= ex_wr_reg;
      mem_ld_reg <= ex_ld_reg;
      mem_st_reg <= ex_st_reg;
      mem_rd_reg <= ex_rd_reg;
      wb_v_reg   <= mem_v_reg;
      wb_wr_reg  <= mem_wr_reg;
      wb_rd_reg  <= mem_rd_reg;
    end
  end

  logic [1:0][REG_AW-1:0] src_w;
  logic [1:0]             used_w, ex_hit, wb_hit, ld_hit;
  logic [1:0][1:0]        fwd_w;
  logic                   ex_fwd_ok, wb_fwd_ok;

  assign src_w  = {id_rs2, id_rs1};
  assign used_w = {id_rs2_used, id_rs1_used};

  // A load's data is not ready in EX, and PC writes are never bypassed.
  assign ex_fwd_ok = ex_v_reg & ex_wr_reg & ~ex_ld_reg & (ex_rd_reg != REG_AW'(REG_PC));
  assign wb_fwd_ok = wb_v_reg & wb_wr_reg & (wb_rd_reg != REG_AW'(REG_PC));

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign ex_hit[gi] = used_w[gi] & ex_fwd_ok & (ex_rd_reg == src_w[gi]);
      assign wb_hit[gi] = used_w[gi] & wb_fwd_ok & (wb_rd_reg == src_w[gi]);
      assign ld_hit[gi] = used_w[gi] & ex_v_reg & ex_ld_reg & (ex_rd_reg == src_w[gi]);
      assign fwd_w[gi]  = ex_hit[gi] ? FWD_EXMEM : (wb_hit[gi] ? FWD_MEMWB : FWD_REG);
    end
  endgenerate

  assign fwd_a    = fwd_w[0];
  assign fwd_b    = fwd_w[1];
  assign load_use = id_valid & (|ld_hit);
  assign mem_pend = mem_v_reg & (mem_ld_reg | mem_st_reg);

endmodule

// File: rtl/hazard_scheduler.sv
// Pipeline sequencing FSM: stalls, flushes and freezes the 5-stage pipe for
// load-use, taken branches and slow data-memory accesses.
module hazard_scheduler
  import hazard_scheduler_pkg::*;
#(
  parameter int REG_AW      = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic              id_rs1_used,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              ex_branch_taken,
  input  logic              dmem_ack,
  output logic              pc_en,
  output logic              pc_sel_target,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_en,
  output logic              idex_flush,
  output logic              exmem_en,
  output logic              dmem_req,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mem_err,
  output logic [1:0]        state_o
);

  localparam logic [3:0] TMO = 4'(MEM_TIMEOUT);

  state_t     state_reg, state_next;
  logic [3:0] wait_cnt_reg, wait_cnt_next;
  logic       mem_err_reg, mem_err_next;
  logic       load_use, mem_pend;
  logic [1:0] sb_fwd_a, sb_fwd_b;

  hazard_scoreboard #(.REG_AW(REG_AW)) u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .shift_en     (exmem_en),
    .load_en      (idex_en & ~idex_flush),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs1_used  (id_rs1_used),
    .id_rs2       (id_rs2),
    .id_rs2_used  (id_rs2_used),
    .id_rd        (id_rd),
    .id_regwrite  (id_regwrite),
    .id_mem_read  (id_mem_read),
    .id_mem_write (id_mem_write),
    .fwd_a        (sb_fwd_a),
    .fwd_b        (sb_fwd_b),
    .load_use     (load_use),
    .mem_pend     (mem_pend)
  );

  always_comb begin
    pc_en         = 1'b1;
    pc_sel_target = 1'b0;
    ifid_en       = 1'b1;
    ifid_flush    = 1'b0;
    idex_en       = 1'b1;
    idex_flush    = 1'b0;
    exmem_en      = 1'b1;
    dmem_req      = mem_pend & ~dmem_ack;
    state_next    = state_reg;
    wait_cnt_next = 4'd0;
    mem_err_next  = mem_err_reg;
    case (state_reg)
      ST_RUN: begin
        // Memory wait outranks a branch; the branch stays in the frozen EX.
        if (mem_pend && !dmem_ack) begin
          pc_en         = 1'b0;
          ifid_en       = 1'b0;
          idex_en       = 1'b0;
          exmem_en      = 1'b0;
          wait_cnt_next = 4'd1;
          state_next    = ST_MEMWAIT;
        end else if (ex_branch_taken) begin
          pc_sel_target = 1'b1;
          ifid_flush    = 1'b1;
          idex_flush    = 1'b1;
          state_next    = ST_BRFLUSH;
        end else if (load_use) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
          state_next = ST_LDSTALL;
        end
      end
      ST_LDSTALL: state_next = ST_RUN;
      ST_BRFLUSH: begin
        ifid_flush = 1'b1;
        state_next = ST_RUN;
      end
      ST_MEMWAIT: begin
        pc_en         = 1'b0;
        ifid_en       = 1'b0;
        idex_en       = 1'b0;
        exmem_en      = 1'b0;
        wait_cnt_next = wait_cnt_reg + 4'd1;
        if (dmem_ack) begin
          exmem_en      = 1'b1;
          wait_cnt_next = 4'd0;
          state_next    = ST_RUN;
        end else if (wait_cnt_next == TMO) begin
          exmem_en      = 1'b1;
          dmem_req      = 1'b0;
          mem_err_next  = 1'b1;
          wait_cnt_next = 4'd0;
          state_next    = ST_RUN;
        end
      end
      default: state_next = ST_RUN;
    endcase
    if (reset) begin
      pc_en         = 1'b0;
      pc_sel_target = 1'b0;
      ifid_en       = 1'b0;
      ifid_flush    = 1'b1;
      idex_en       = 1'b0;
      idex_flush    = 1'b1;
      exmem_en      = 1'b0;
      dmem_req      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_RUN;
      wait_cnt_reg <= 4'd0;
      mem_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      mem_err_reg  <= mem_err_next;
    end
  end

  assign fwd_a   = reset ? FWD_REG : sb_fwd_a;
  assign fwd_b   = reset ? FWD_REG : sb_fwd_b;
  assign mem_err = mem_err_reg & ~reset;
  assign state_o = reset ? 2'b00 : 2'(state_reg);

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench: the driver pushes one expected output vector per cycle and
// a negedge monitor pops and compares it against the live DUT outputs.
module tb_hazard_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       id_valid = 1'b0, id_rs1_used = 1'b0, id_rs2_used = 1'b0;
  logic [3:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_regwrite = 1'b0, id_mem_read = 1'b0, id_mem_write = 1'b0;
  logic       ex_branch_taken = 1'b0, dmem_ack = 1'b0;
  logic       pc_en, pc_sel_target, ifid_en, ifid_flush, idex_en, idex_flush;
  logic       exmem_en, dmem_req, mem_err;
  logic [1:0] fwd_a, fwd_b, state_o;

  always #5 clk = ~clk;

  hazard_scheduler #(.REG_AW(4), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .ex_branch_taken(ex_branch_taken), .dmem_ack(dmem_ack),
    .pc_en(pc_en), .pc_sel_target(pc_sel_target), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_flush(idex_flush),
    .exmem_en(exmem_en), .dmem_req(dmem_req), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_err(mem_err), .state_o(state_o)
  );

  // Control byte order: pc_en, pc_sel, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, dmem_req
  localparam logic [7:0] C_IDLE = 8'b1010_1010;
  localparam logic [7:0] C_RST  = 8'b0001_0100;
  localparam logic [7:0] C_LDU  = 8'b0000_1110;
  localparam logic [7:0] C_BR   = 8'b1111_1110;
  localparam logic [7:0] C_BRF  = 8'b1011_1010;
  localparam logic [7:0] C_FRZ  = 8'b0000_0001;
  localparam logic [7:0] C_ACK  = 8'b0000_0010;
  localparam logic [14:0] M_ALL = 15'h7fff;
  localparam logic [14:0] M_NOFWD = 15'b11111111_0000_111;

  typedef struct {
    string       nm;
    logic [14:0] exp;
    logic [14:0] mask;
  } txn_t;

  txn_t q[$];
  int   n_tests = 0;
  int   n_fail = 0;

  function automatic logic [14:0] mk(input logic [7:0] ctl, input logic [1:0] fa,
                                     input logic [1:0] fb, input logic err, input logic [1:0] st);
    return {ctl, fa, fb, err, st};
  endfunction

  task automatic set_id(input logic v, input logic [3:0] r1, input logic u1,
                        input logic [3:0] r2, input logic u2, input logic [3:0] rd,
                        input logic rw, input logic mr, input logic mw);
    id_valid = v; id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
    id_rd = rd; id_regwrite = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic bubble();
    set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step_m(input string nm, input logic [14:0] exp, input logic [14:0] mask);
    txn_t t;
    t.nm = nm; t.exp = exp; t.mask = mask;
    q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string nm, input logic [14:0] exp);
    step_m(nm, exp, M_ALL);
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      txn_t        t;
      logic [14:0] act;
      t   = q.pop_front();
      act = {pc_en, pc_sel_target, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
             dmem_req, fwd_a, fwd_b, mem_err, state_o};
      n_tests++;
      if (((act ^ t.exp) & t.mask) !== 15'd0) begin
        n_fail++;
        $display("[TB] FAIL %s: got %b required %b (care %b)", t.nm, act, t.exp, t.mask);
      end else begin
        $display("[TB] ok   %s: %b", t.nm, act);
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    step("reset_a", mk(C_RST, 2'b00, 2'b00, 1'b0, 2'd0));
    step("reset_b", mk(C_RST, 2'b00, 2'b00, 1'b0, 2'd0));
    reset = 1'b0;

    // Forwarding: producer ADD R1, then consumers with ex/wb matches.
    set_id(1, 4'd2, 1, 4'd3, 1, 4'd1, 1, 0, 0);
    step("fwd_add_r1", mk(C_IDLE, 2'b00, 2'b00, 1'b0, 2'd0));
    set_id(1, 4'd1, 1, 4'd5, 1, 4'd4, 1, 0, 0);
    step("fwd_sub_ex", mk(C_IDLE, 2'b01, 2'b00, 1'b0, 2'd0));
    set_id(1, 4'd1, 1, 4'd4, 1, 4'd4, 1, 0, 0);
    step("fwd_b_ex", mk(C_IDLE, 2'b00, 2'b01, 1'b0, 2'd0));
    set_id(1, 4'd1, 1, 4'd4, 1, 4'd15, 1, 0, 0);
    step("fwd_wb_ex", mk(C_IDLE, 2'b10, 2'b01, 1'b0, 2'd0));
    set_id(1, 4'd15, 1, 4'd4, 1, 4'd4, 1, 0, 0);
    step("fwd_no_pc", mk(C_IDLE, 2'b00, 2'b10, 1'b0, 2'd0));
    set_id(1, 4'd4, 1, 4'd4, 0, 4'd0, 0, 0, 0);
    step("fwd_ex_prio", mk(C_IDLE, 2'b01, 2'b00, 1'b0, 2'd0));
    set_id(1, 4'd15, 1, 4'd0, 0, 4'd0, 0, 0, 0);
    step("fwd_wb_pc", mk(C_IDLE, 2'b00, 2'b00, 1'b0, 2'd0));
    bubble();
    step("drain_a", mk(C_IDLE, 2'b00, 2'b00, 1'b0, 2'd0));
    step("drain_b", mk(C_IDLE, 2'b00, 2'b00, 1'b0, 2'd0));

    // Load-use: LDR R2 then ADD reading R2.
    set_id(1, 4'd13, 1, 4'd0, 0, 4'd2, 1, 1, 0);
    step("ld_issue", mk(C_IDLE, 2'b00, 2'b00, 1'b0, 2'd0));
    set_id(1, 4'd5, 1, 4'd2, 1, 4'd3, 1, 0, 0);
    step("ld_use", mk(C_LDU, 2'b00, 2'b00, 1'b0, 2'd0));
    dmem_ack = 1'b1;
    step_m("ld_stall", mk(C_IDLE, 2'b00, 2'b00, 1'b0, 2'd1), M_NOFWD);
    dmem_ack = 1'b0;
    set_id(1, 4'd2, 1, 4'd3, 1, 4'd6, 1, 0, 0);
    step("ld_wb_fwd", mk(C_IDLE, 2'b10, 2'b01, 1'b0, 2'd0));
    bubble();
    step("ld_drain_a", mk(C_IDLE, 2'b00, 2'b00, 1'b0, 2'd0));
    step("ld_drain_b", mk(C_IDLE, 2'b00, 2'b00, 1'b0, 2'd0));

    // Taken branch that coincides with a load-use.
    set_id(1, 4'd13, 1, 4'd0, 0, 4'd8, 1, 1, 0);
    step("br_ld_issue", mk(C_IDLE, 2'b00, 2'b00, 1'b0, 2'd0));
    set_id(1, 4'd8, 1, 4'd0, 0, 4'd9, 1, 0, 0);
    ex_branch_taken = 1'b1;
    step("br_taken", mk(C_BR, 2'b00, 2'b00, 1'b0, 2'd0));
    ex_branch_taken = 1'b0;
    dmem_ack = 1'b1;
    bubble();
    step("br_flush", mk(C_BRF, 2'b00, 2'b00, 1'b0, 2'd2));
    dmem_ack = 1'b0;
    step("br_resume", mk(C_IDLE, 2'b00, 2'b00, 1'b0, 2'd0));

    // Store in MEM with ack after three frozen cycles; branch held meanwhile.
    set_id(1, 4'd13, 1, 4'd4, 1, 4'd0, 0, 0, 1);
    step("st_issue", mk(C_IDLE, 2'b00, 2'b00, 1'b0, 2'd0));
    set_id(1, 4'd11, 1, 4'd0, 0, 4'd10, 1, 0, 0);
    step("st_add_r10", mk(C_IDLE, 2'b00, 2'b00, 1'b0, 2'd0));
    set_id(1, 4'd10, 1, 4'd0, 0, 4'd0, 0, 0, 0);
    ex_branch_taken = 1'b1;
    step("st_freeze", mk(C_FRZ, 2'b01, 2'b00, 1'b0, 2'd0));
    step("st_wait_1", mk(C_FRZ, 2'b01, 2'b00, 1'b0, 2'd3));
    step("st_wait_2", mk(C_FRZ, 2'b01, 2'b00, 1'b0, 2'd3));
    dmem_ack = 1'b1;
    step("st_ack", mk(C_ACK, 2'b01, 2'b00, 1'b0, 2'd3));
    dmem_ack = 1'b0;
    step("st_br_resume", mk(C_BR, 2'b00, 2'b00, 1'b0, 2'd0));
    ex_branch_taken = 1'b0;
    bubble();
    step("st_brflush", mk(C_BRF, 2'b00, 2'b00, 1'b0, 2'd2));
    step("st_idle", mk(C_IDLE, 2'b00, 2'b00, 1'b0, 2'd0));

    // Load whose ack never arrives: timeout after 15 waiting cycles.
    set_id(1, 4'd13, 1, 4'd0, 0, 4'd5, 1, 1, 0);
    step("to_issue", mk(C_IDLE, 2'b00, 2'b00, 1'b0, 2'd0));
    bubble();
    step("to_bubble", mk(C_IDLE, 2'b00, 2'b00, 1'b0, 2'd0));
    step("to_freeze", mk(C_FRZ, 2'b00, 2'b00, 1'b0, 2'd0));
    for (int i = 1; i <= 13; i++)
      step($sformatf("to_wait_%0d", i), mk(C_FRZ, 2'b00, 2'b00, 1'b0, 2'd3));
    step("to_expire", mk(C_ACK, 2'b00, 2'b00, 1'b0, 2'd3));
    step("to_err_set", mk(C_IDLE, 2'b00, 2'b00, 1'b1, 2'd0));
    dmem_ack = 1'b1;
    step("to_stray_ack", mk(C_IDLE, 2'b00, 2'b00, 1'b1, 2'd0));
    dmem_ack = 1'b0;

    // Reset in the middle of a memory wait.
    set_id(1, 4'd13, 1, 4'd0, 0, 4'd0, 0, 0, 1);
    step("rw_st_issue", mk(C_IDLE, 2'b00, 2'b00, 1'b1, 2'd0));
    set_id(1, 4'd0, 0, 4'd0, 0, 4'd12, 1, 0, 0);
    step("rw_add_r12", mk(C_IDLE, 2'b00, 2'b00, 1'b1, 2'd0));
    set_id(1, 4'd12, 1, 4'd0, 0, 4'd0, 0, 0, 0);
    step("rw_freeze", mk(C_FRZ, 2'b01, 2'b00, 1'b1, 2'd0));
    step("rw_wait", mk(C_FRZ, 2'b01, 2'b00, 1'b1, 2'd3));
    reset = 1'b1;
    step("rw_reset", mk(C_RST, 2'b00, 2'b00, 1'b0, 2'd0));
    reset = 1'b0;
    step("rw_after_a", mk(C_IDLE, 2'b00, 2'b00, 1'b0, 2'd0));
    bubble();
    step("rw_after_b", mk(C_IDLE, 2'b00, 2'b00, 1'b0, 2'd0));

    for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      $display("[TB] FAIL drain: %0d pending, required 0", q.size());
      $fatal(1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
